// File: rtl/debounce_pkg.sv
// Shared types for the debounce slice.
package debounce_pkg;

   typedef enum logic {
      STABLE  = 1'b0,
      CONFIRM = 1'b1
   } debounce_state_e;

endpackage

// File: rtl/debounce_if.sv
// Debouncer signal bundle: threshold and raw input in, conditioned level and pulses out.
interface debounce_if #(
   parameter int unsigned CNT_WIDTH = 16
);

   logic [CNT_WIDTH-1:0] cnt_max_i;
   logic                 d_i;
   logic                 q_o;
   logic                 rise_o;
   logic                 fall_o;
   logic                 busy_o;

   modport master (
      output cnt_max_i, d_i,
      input  q_o, rise_o, fall_o, busy_o
   );

   modport slave (
      input  cnt_max_i, d_i,
      output q_o, rise_o, fall_o, busy_o
   );

endinterface

// File: rtl/debounce_dff.sv
// Single-bit enabled flop with asynchronous active-low reset to a parameterised value.
module dff #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk_i,
   input  logic arst_ni,
   input  logic en_i,
   input  logic d_i,
   output logic q_o
);

   logic q_q;

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         q_q <= RESET_VALUE;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/debounce.sv
// Synchronises an asynchronous input and commits a new level only after it has
// persisted for cnt_max_i+1 consecutive confirm cycles; emits one-cycle edge pulses.
module debounce
   import debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_WIDTH   = 16,
   parameter logic        RESET_VALUE = 1'b0
) (
   input logic       clk_i,
   input logic       arst_ni,
   debounce_if.slave bus
);

   logic [SYNC_STAGES:0] sync;
   logic                 s;

   assign sync[0] = bus.d_i;

   for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
      dff #(
         .RESET_VALUE(RESET_VALUE)
      ) u_dff (
         .clk_i  (clk_i),
         .arst_ni(arst_ni),
         .en_i   (1'b1),
         .d_i    (sync[i]),
         .q_o    (sync[i+1])
      );
   end

   assign s = sync[SYNC_STAGES];

   debounce_state_e      state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 q_q, q_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      q_d     = q_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         STABLE: begin
            if (s != q_q) state_d = CONFIRM;
         end
         CONFIRM: begin
            if (s == q_q) begin
               state_d = STABLE;
            end else if (cnt_q >= bus.cnt_max_i) begin
               // >= rather than == so a threshold lowered below cnt commits immediately
               q_d     = s;
               rise_d  = s;
               fall_d  = ~s;
               state_d = STABLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= STABLE;
         cnt_q   <= '0;
         q_q     <= RESET_VALUE;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign bus.q_o    = q_q;
   assign bus.rise_o = rise_q;
   assign bus.fall_o = fall_q;
   assign bus.busy_o = (state_q == CONFIRM);

endmodule
